cu_seq: RTL

Sequencing control unit for the pipelined processor's decode stage, successor to the purely combinational decoder. It decodes the 8-bit opcode into per-stage control signals in one cycle for ordinary instructions. CALL, RET, RTI and interrupt entry run as multi-cycle micro-sequences that stall fetch/decode and drive the stack one word per cycle. Interrupt inputs, PC stack width and vector width are parametrised; in-service tracking blocks nested interrupts.

---
 rtl/cu_seq_if.sv | 46 ++++
 rtl/cu_seq.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_seq_if.sv
// Decode-stage control bundle: opcode/interrupt inputs and
// per-stage control outputs of the sequencing control unit.
interface cu_seq_if #(
    parameter int NUM_INT = 2,
    parameter int VEC_W   = 1
);
    logic [7:0]         opcode;
    logic               op_valid;
    logic [NUM_INT-1:0] int_req;
    logic               mem_busy;

    logic               stall;
    logic [NUM_INT-1:0] int_ack;
    logic               wb;
    logic               alu_en;
    logic               imm;
    logic               mr;
    logic               mw;
    logic               jmp;
    logic               ior;
    logic               iow;
    logic [2:0]         alu_ops;
    logic               stack_en;
    logic               stack_pop;
    logic [1:0]         stack_sel;
    logic [3:0]         word_idx;
    logic               pc_load;
    logic               flags_load;
    logic               vec_load;
    logic [VEC_W-1:0]   vec;
    logic               in_isr;

    modport master (
        output opcode, op_valid, int_req, mem_busy,
        input  stall, int_ack, wb, alu_en, imm, mr, mw, jmp,
        input  ior, iow, alu_ops, stack_en, stack_pop, stack_sel,
        input  word_idx, pc_load, flags_load, vec_load, vec, in_isr
    );

    modport slave (
        input  opcode, op_valid, int_req, mem_busy,
        output stall, int_ack, wb, alu_en, imm, mr, mw, jmp,
        output ior, iow, alu_ops, stack_en, stack_pop, stack_sel,
        output word_idx, pc_load, flags_load, vec_load, vec, in_isr
    );
endinterface

// File: rtl/cu_seq.sv
// Sequencing control unit: single-cycle decode for ordinary opcodes,
// multi-cycle stack micro-sequences for CALL/RET/RTI/interrupt entry.
module cu_seq #(
    parameter int NUM_INT  = 2,
    parameter int VEC_W    = 1,
    parameter int PC_WORDS = 2
) (
    input logic   clk,
    input logic   rst,
    cu_seq_if.slave bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CALL_PC = 3'd1;
    localparam logic [2:0] S_RET_PC  = 3'd2;
    localparam logic [2:0] S_RTI_FLG = 3'd3;
    localparam logic [2:0] S_INT_PC  = 3'd4;
    localparam logic [2:0] S_INT_FLG = 3'd5;
    localparam logic [2:0] S_INT_VEC = 3'd6;

    localparam logic [1:0] SEL_DATA = 2'b00;
    localparam logic [1:0] SEL_PC   = 2'b01;
    localparam logic [1:0] SEL_FLG  = 2'b10;

    localparam logic [3:0] LAST_W = 4'(PC_WORDS - 1);

    logic [2:0]         r_state;
    logic [3:0]         r_widx;
    logic               r_in_isr;
    logic               r_rti;
    logic [VEC_W-1:0]   r_vec;

    logic [2:0]         w_state_nx;
    logic [3:0]         w_widx_nx;
    logic               w_in_isr_nx;
    logic               w_rti_nx;
    logic [VEC_W-1:0]   w_vec_nx;

    logic [2:0]         w_cls;
    logic               w_op0;
    logic               w_is_alu;
    logic               w_is_ld;
    logic               w_is_st;
    logic               w_is_jmp;
    logic               w_is_io;
    logic               w_is_stk;
    logic               w_is_imm;
    logic               w_is_call;
    logic               w_is_ret;
    logic               w_is_rti;

    logic               w_found;
    logic [VEC_W-1:0]   w_pick;
    logic [NUM_INT-1:0] w_ack_oh;
    logic               w_accept;
    logic               w_busy;
    logic               w_last_up;
    logic               w_last_dn;

    logic               w_stall;
    logic [NUM_INT-1:0] w_ack;
    logic               w_wb;
    logic               w_alu_en;
    logic               w_imm;
    logic               w_mr;
    logic               w_mw;
    logic               w_jmp;
    logic               w_ior;
    logic               w_iow;
    logic [2:0]         w_alu_ops;
    logic               w_stack_en;
    logic               w_stack_pop;
    logic [1:0]         w_stack_sel;
    logic [3:0]         w_word_idx;
    logic               w_pc_load;
    logic               w_flags_load;
    logic               w_vec_load;

    assign w_cls     = bus.opcode[5:3];
    assign w_op0     = bus.opcode[0];
    assign w_is_alu  = (w_cls == 3'b000);
    assign w_is_ld   = (w_cls == 3'b001);
    assign w_is_st   = (w_cls == 3'b010);
    assign w_is_jmp  = (w_cls == 3'b011);
    assign w_is_io   = (w_cls == 3'b101);
    assign w_is_stk  = (w_cls == 3'b111);
    assign w_is_imm  = (bus.opcode[7:6] == 2'b01);
    assign w_is_call = (bus.opcode[7:3] == 5'b10110);
    assign w_is_ret  = (bus.opcode[7:3] == 5'b11110) & ~w_op0;
    assign w_is_rti  = (bus.opcode[7:3] == 5'b11110) & w_op0;

    // Lowest-numbered pending request wins.
    always_comb begin
        w_found  = 1'b0;
        w_pick   = '0;
        w_ack_oh = '0;
        for (int i = 0; i < NUM_INT; i++) begin
            if (bus.int_req[i] && !w_found) begin
                w_found     = 1'b1;
                w_pick      = VEC_W'(i);
                w_ack_oh[i] = 1'b1;
            end
        end
    end

    assign w_accept  = (r_state == S_IDLE) & ~r_in_isr & w_found;
    assign w_busy    = bus.mem_busy;
    assign w_last_up = (r_widx == LAST_W);
    assign w_last_dn = (r_widx == 4'd0);

    always_comb begin
        w_state_nx   = r_state;
        w_widx_nx    = r_widx;
        w_in_isr_nx  = r_in_isr;
        w_rti_nx     = r_rti;
        w_vec_nx     = r_vec;
        w_stall      = 1'b0;
        w_ack        = '0;
        w_wb         = 1'b0;
        w_alu_en     = 1'b0;
        w_imm        = 1'b0;
        w_mr         = 1'b0;
        w_mw         = 1'b0;
        w_jmp        = 1'b0;
        w_ior        = 1'b0;
        w_iow        = 1'b0;
        w_alu_ops    = 3'b000;
        w_stack_en   = 1'b0;
        w_stack_pop  = 1'b0;
        w_stack_sel  = SEL_DATA;
        w_word_idx   = 4'd0;
        w_pc_load    = 1'b0;
        w_flags_load = 1'b0;
        w_vec_load   = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_stall     = 1'b1;
                    w_ack       = w_ack_oh;
                    w_vec_nx    = w_pick;
                    w_in_isr_nx = 1'b1;
                    w_widx_nx   = 4'd0;
                    w_state_nx  = S_INT_PC;
                end else if (bus.op_valid) begin
                    unique case (1'b1)
                        w_is_call: begin
                            w_stall    = 1'b1;
                            w_widx_nx  = 4'd0;
                            w_state_nx = S_CALL_PC;
                        end
                        w_is_ret: begin
                            w_stall    = 1'b1;
                            w_widx_nx  = LAST_W;
                            w_rti_nx   = 1'b0;
                            w_state_nx = S_RET_PC;
                        end
                        w_is_rti: begin
                            w_stall    = 1'b1;
                            w_rti_nx   = 1'b1;
                            w_state_nx = S_RTI_FLG;
                        end
                        default: begin
                            w_alu_ops   = bus.opcode[2:0];
                            w_imm       = w_is_imm;
                            w_alu_en    = w_is_alu;
                            w_jmp       = w_is_jmp;
                            w_ior       = w_is_io & ~w_op0;
                            w_iow       = w_is_io & w_op0;
                            w_stack_en  = w_is_stk;
                            w_stack_pop = w_is_stk & w_op0;
                            w_mr        = w_is_ld | (w_is_stk & w_op0);
                            w_mw        = w_is_st | (w_is_stk & ~w_op0);
                            w_wb        = w_is_alu | w_is_ld | w_is_imm
                                        | (w_is_io & ~w_op0)
                                        | (w_is_stk & w_op0);
                        end
                    endcase
                end
            end

            S_CALL_PC: begin
                w_stall     = 1'b1;
                w_stack_en  = 1'b1;
                w_stack_sel = SEL_PC;
                w_word_idx  = r_widx;
                w_mw        = 1'b1;
                w_jmp       = w_last_up;
                if (!w_busy) begin
                    if (w_last_up) begin
                        w_widx_nx  = 4'd0;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_widx_nx = r_widx + 4'd1;
                    end
                end
            end

            S_INT_PC: begin
                w_stall     = 1'b1;
                w_stack_en  = 1'b1;
                w_stack_sel = SEL_PC;
                w_word_idx  = r_widx;
                w_mw        = 1'b1;
                if (!w_busy) begin
                    if (w_last_up) begin
                        w_widx_nx  = 4'd0;
                        w_state_nx = S_INT_FLG;
                    end else begin
                        w_widx_nx = r_widx + 4'd1;
                    end
                end
            end

            S_INT_FLG: begin
                w_stall     = 1'b1;
                w_stack_en  = 1'b1;
                w_stack_sel = SEL_FLG;
                w_mw        = 1'b1;
                if (!w_busy) begin
                    w_state_nx = S_INT_VEC;
                end
            end

            // Vector fetch goes through the fetch unit, not the stack.
            S_INT_VEC: begin
                w_stall    = 1'b1;
                w_vec_load = 1'b1;
                w_state_nx = S_IDLE;
            end

            S_RTI_FLG: begin
                w_stall      = 1'b1;
                w_stack_en   = 1'b1;
                w_stack_pop  = 1'b1;
                w_stack_sel  = SEL_FLG;
                w_mr         = 1'b1;
                w_flags_load = 1'b1;
                if (!w_busy) begin
                    w_widx_nx  = LAST_W;
                    w_state_nx = S_RET_PC;
                end
            end

            S_RET_PC: begin
                w_stall     = 1'b1;
                w_stack_en  = 1'b1;
                w_stack_pop = 1'b1;
                w_stack_sel = SEL_PC;
                w_word_idx  = r_widx;
                w_mr        = 1'b1;
                w_pc_load   = 1'b1;
                w_jmp       = w_last_dn;
                if (!w_busy) begin
                    if (w_last_dn) begin
                        w_state_nx = S_IDLE;
                        if (r_rti) begin
                            w_in_isr_nx = 1'b0;
                        end
                    end else begin
                        w_widx_nx = r_widx - 4'd1;
                    end
                end
            end

            default: begin
                w_widx_nx  = 4'd0;
                w_state_nx = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_widx   <= 4'd0;
            r_in_isr <= 1'b0;
            r_rti    <= 1'b0;
            r_vec    <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_widx   <= w_widx_nx;
            r_in_isr <= w_in_isr_nx;
            r_rti    <= w_rti_nx;
            r_vec    <= w_vec_nx;
        end
    end

    // Everything is forced low while reset is asserted, mid-sequence too.
    assign bus.stall      = w_stall & ~rst;
    assign bus.int_ack    = rst ? '0 : w_ack;
    assign bus.wb         = w_wb & ~rst;
    assign bus.alu_en     = w_alu_en & ~rst;
    assign bus.imm        = w_imm & ~rst;
    assign bus.mr         = w_mr & ~rst;
    assign bus.mw         = w_mw & ~rst;
    assign bus.jmp        = w_jmp & ~rst;
    assign bus.ior        = w_ior & ~rst;
    assign bus.iow        = w_iow & ~rst;
    assign bus.alu_ops    = rst ? 3'b000 : w_alu_ops;
    assign bus.stack_en   = w_stack_en & ~rst;
    assign bus.stack_pop  = w_stack_pop & ~rst;
    assign bus.stack_sel  = rst ? 2'b00 : w_stack_sel;
    assign bus.word_idx   = rst ? 4'd0 : w_word_idx;
    assign bus.pc_load    = w_pc_load & ~rst;
    assign bus.flags_load = w_flags_load & ~rst;
    assign bus.vec_load   = w_vec_load & ~rst;
    assign bus.vec        = rst ? '0 : r_vec;
    assign bus.in_isr     = r_in_isr & ~rst;
endmodule
